// File: rtl/qam_frame_ctrl.sv
// qam_frame_ctrl: frames preamble, payload, zero tail and idle gap into qam_top.
// Ports: axi_clk/axi_rst, start/frame_len cmd, busy/done, s_* upstream, din_* downstream, stats.
module qam_frame_ctrl #(
  parameter int PRE_LEN  = 16,
  parameter int TAIL_LEN = 4,
  parameter int GAP_CYC  = 32,
  parameter int LEN_W    = 10
) (
  input  logic             axi_clk,
  input  logic             axi_rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             done,
  input  logic             s_valid,
  input  logic [3:0]       s_data,
  output logic             s_ready,
  output logic             din_valid,
  output logic [3:0]       din,
  input  logic             din_ready,
  output logic [15:0]      underrun_cnt,
  output logic [15:0]      frame_cnt
);

  localparam int PW = $clog2(PRE_LEN);
  localparam int TW = $clog2(TAIL_LEN + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_PAY, S_TAIL, S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [LEN_W-1:0] pay_q, pay_d;
  logic [TW-1:0]    tail_q, tail_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             done_q, done_d;
  logic [15:0]      urun_q, urun_d;
  logic [15:0]      fcnt_q, fcnt_d;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pre_d     = pre_q;
    pay_d     = pay_q;
    tail_d    = tail_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    urun_d    = urun_q;
    fcnt_d    = fcnt_q;
    din_valid = 1'b0;
    din       = 4'h0;
    s_ready   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && frame_len != '0) begin
          len_d   = frame_len;
          pre_d   = '0;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        din_valid = 1'b1;
        // odd preamble index carries 4'hF
        din = pre_q[0] ? 4'hF : 4'h0;
        if (din_ready) begin
          if (pre_q == PW'(PRE_LEN - 1)) begin
            pre_d   = '0;
            pay_d   = '0;
            state_d = S_PAY;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
      end
      S_PAY: begin
        din_valid = s_valid;
        din       = s_data;
        s_ready   = din_ready;
        if (din_ready && !s_valid && urun_q != 16'hFFFF)
          urun_d = urun_q + 16'd1;
        if (din_ready && s_valid) begin
          if (pay_q == len_q - LEN_W'(1)) begin
            pay_d   = '0;
            tail_d  = '0;
            state_d = S_TAIL;
          end else begin
            pay_d = pay_q + 1'b1;
          end
        end
      end
      S_TAIL: begin
        din_valid = 1'b1;
        if (din_ready) begin
          if (tail_q == TW'(TAIL_LEN - 1)) begin
            tail_d  = '0;
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            tail_d = tail_q + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          gap_d   = '0;
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      pre_q   <= '0;
      pay_q   <= '0;
      tail_q  <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      urun_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pre_q   <= pre_d;
      pay_q   <= pay_d;
      tail_q  <= tail_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign underrun_cnt = urun_q;
  assign frame_cnt    = fcnt_q;

endmodule

// File: doc/qam_frame_ctrl.md
# qam_frame_ctrl

Frame sequencer in front of the 16-QAM modulator (`qam_top`). On a start command it drives the modulator's 4-bit symbol input in order:
- a fixed preamble;
- a programmable-length payload taken from an upstream symbol stream;
- a short zero tail;
- an inter-frame idle gap.

It reports busy/done status and underrun and frame statistics, and is the only master of `qam_top`'s `din_valid`/`din`/`din_ready` handshake.

## Interface
Parameters:
- PRE_LEN, 16, preamble symbol count (>=2, even).
- TAIL_LEN, 4, tail symbol count, value 4'h0 (>=1).
- GAP_CYC, 32, idle cycles after the tail (>=1).
- LEN_W, 10, width of frame_len.

Ports:
- axi_clk  in  1  clock; the only clock.
- axi_rst  in  1  reset; synchronous, active-high.
- start  in  1  frame request; sampled only in IDLE.
- frame_len  in  LEN_W  payload symbol count; latched on accepted start; 0 = request rejected.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame completion.
- s_valid  in  1  upstream payload symbol valid.
- s_data  in  4  upstream payload symbol.
- s_ready  out  1  upstream accept.
- din_valid  out  1  symbol valid to qam_top.
- din  out  4  symbol to qam_top.
- din_ready  in  1  qam_top symbol accept.
- underrun_cnt  out  16  saturating count of PAY cycles with din_ready=1, s_valid=0.
- frame_cnt  out  16  completed frames, wraps at 2^16.

## Operation
- States: IDLE, PRE, PAY, TAIL, GAP.
- Transfer definition:
  - downstream transfer = din_valid & din_ready;
  - upstream transfer = s_valid & s_ready.
- IDLE:
  - start=1 with frame_len!=0 latches len and goes to PRE;
  - start=1 with frame_len=0 is ignored (stay IDLE).
- PRE:
  - din_valid=1; din alternates 4'h0, 4'hF, 4'h0, … starting with 4'h0, indexed by a transfer counter;
  - after PRE_LEN transfers, go to PAY.
- PAY is a combinational pass-through:
  - din_valid=s_valid, din=s_data, s_ready=din_ready;
  - after len transfers, go to TAIL.
- TAIL:
  - din_valid=1, din=4'h0;
  - after TAIL_LEN transfers, go to GAP.
- GAP:
  - din_valid=0; a cycle counter runs GAP_CYC cycles, then the block goes to IDLE.
- Outside PAY: s_ready=0.
- Outside PRE/PAY/TAIL: din_valid=0 and din=4'h0.
- Stability: din is stable whenever din_valid=1 and din_ready=0. In PAY this holds provided upstream obeys the valid/ready rules. In PRE/TAIL, din changes only after a transfer.
- start is ignored in every state other than IDLE, including GAP.
- underrun_cnt increments on PAY cycles with din_ready=1 and s_valid=0; it saturates at 16'hFFFF.
- frame_cnt increments on the done cycle.
- Counters (preamble/payload/tail index and gap cycle counter) are sized to their parameter; the payload counter is LEN_W bits, compared against the latched len.

## Timing
- Reset (axi_rst=1 on a clock edge): on the next cycle, state=IDLE and all counters=0. Every output reads 0: busy, done, s_ready, din_valid, din, underrun_cnt, frame_cnt.
- Reset mid-frame aborts immediately: no done, and no further symbols are issued.
- Start latency: start accepted at edge N gives busy=1 and din_valid=1 with din=4'h0 in cycle N+1.
- PRE→PAY: the edge carrying the PRE_LEN-th transfer moves state to PAY; the first payload symbol can transfer in the next cycle.
- PAY→TAIL and TAIL→GAP: same rule; state advances on the edge carrying the last transfer.
- GAP runs exactly GAP_CYC cycles with busy=1.
- Completion: in the following cycle state=IDLE, busy=0 and done=1 for one cycle; frame_cnt is already incremented in that cycle.
- start asserted in the done cycle is accepted, giving back-to-back frames.
- Minimum frame duration with din_ready=1 and s_valid=1 throughout: PRE_LEN + len + TAIL_LEN + GAP_CYC busy cycles.
- PAY adds zero latency: s_data→din and din_ready→s_ready are purely combinational.

## Test plan
- Reset: hold axi_rst 10 cycles, then release → all outputs 0, busy stays 0 with start=0.
- Basic frame (defaults), frame_len=8, din_ready=1, upstream 0..7 always valid →
  - din sequence is 0,F×8 pairs (16 symbols), then 0..7, then 0,0,0,0;
  - 32 idle cycles follow;
  - busy high 60 cycles, done one pulse, frame_cnt=1, underrun_cnt=0.
- Backpressure: din_ready high 1 cycle in 4, frame_len=1023, random s_data →
  - din held stable while not ready;
  - the logged payload equals the upstream sequence exactly;
  - busy length = 4·(16+1023+4)−3+32 cycles ±3 depending on ready phase.
- Upstream stall: s_valid=0 for 10 cycles mid-payload with din_ready=1 → din_valid=0 during the stall, underrun_cnt=10, no symbol dropped or duplicated.
- Command rules:
  - start with frame_len=0 → ignored;
  - start during PRE/GAP → ignored;
  - start in the done cycle → the next frame's first din_valid appears the following cycle;
  - frame_cnt=2 after two frames.
- Reset mid-PAY (after 5 payload transfers) → next cycle din_valid=0, s_ready=0, busy=0, no done, frame_cnt=0; a subsequent start runs a full clean frame.
